alu_result_bcd: RTL

Sequential binary-to-BCD converter that sits directly downstream of the ALU. It takes the 9-bit two's-complement ALU result and produces a sign flag plus decimal digits using shift-add-3 (double dabble), one bit per clock. The seven-segment scan logic then displays the result in decimal instead of hex. A start/busy/done handshake lets the display path latch a stable value only when a conversion completes.

---
 rtl/alu_result_bcd.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_result_bcd.sv
// ============================================================================
// Module      : alu_result_bcd
// Description : Serial double-dabble converter from ALU result to sign + BCD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_bcd #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int c_SW = 4*DIGITS + 4;
    localparam int c_CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] c_LIMIT = pow10(DIGITS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_SW-1:0]     r_scratch;
    logic [WIDTH-1:0]    r_mag;
    logic [c_CW-1:0]     r_cnt;
    logic                r_sign;
    logic                r_ovf_pend;
    logic                r_done;
    logic                r_neg;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_ovf;

    logic                w_in_neg;
    logic [WIDTH-1:0]    w_in_mag;
    logic [c_SW-1:0]     w_adj;
    logic [c_SW-1:0]     w_shifted;
    logic                w_last;

    assign w_in_neg = (SIGNED != 0) ? value[WIDTH-1] : 1'b0;
    assign w_in_mag = w_in_neg ? (~value + WIDTH'(1)) : value;

    for (genvar i = 0; i < DIGITS + 1; i++) begin : g_add3
        assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                                 (r_scratch[4*i +: 4] + 4'd3) : r_scratch[4*i +: 4];
    end

    assign w_shifted = {w_adj[c_SW-2:0], r_mag[WIDTH-1]};
    assign w_last    = (r_cnt == c_CW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_next = ST_IDLE;
            default:              w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_scratch  <= '0;
            r_mag      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_neg      <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign     <= w_in_neg;
                        r_mag      <= w_in_mag;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (64'(w_in_mag) >= c_LIMIT);
                    end
                end
                ST_SHIFT: begin
                    r_scratch  <= w_shifted;
                    r_mag      <= r_mag << 1;
                    r_cnt      <= r_cnt + c_CW'(1);
                    // A bit pushed out of the guard nibble is sticky overflow too.
                    r_ovf_pend <= r_ovf_pend | w_adj[c_SW-1];
                    if (w_last) begin
                        r_bcd  <= w_shifted[4*DIGITS-1:0];
                        r_neg  <= r_sign;
                        r_ovf  <= r_ovf_pend | w_adj[c_SW-1] |
                                  (w_shifted[c_SW-1 -: 4] != 4'd0);
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;
    assign neg  = r_neg;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire
